codec_init_seq: RTL and testbench
=================================

// Module: codec_init_seq
// PURPOSE
//  Power-up configuration sequencer for the audio codec on the shield. Walks a fixed table
//  of {reg,data} writes and feeds each transaction byte-by-byte into the i2c byte engine
//  through its DIN/copy_enable interface. Supports timed delay entries and retries on NACK.
//  It is the only master of the i2c engine until done or error; sits between reset logic and i2c.
// PARAMETERS
//  DEV_ADDR     7'h38   codec 7-bit address; first byte sent = {DEV_ADDR,1'b0} = 8'h70
//  N_ENTRIES    16      number of table entries (1..2**IDX_W)
//  IDX_W        4       table index width
//  DELAY_TICKS  25000   clk cycles per delay unit (1 ms at 25 MHz)
//  MAX_RETRY    3       retries per entry after NACK before error
//  RETRY_GAP    1000    clk cycles idle between NACK-abort and retry
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      one-cycle pulse: run table from entry 0
//  i2c_din    out  8      byte to engine (DIN)
//  i2c_load   out  1      one-cycle pulse, engine latches i2c_din (copy_enable)
//  i2c_stop   out  1      valid with i2c_load: STOP after this byte
//  i2c_ready  in   1      engine can accept next byte
//  i2c_idle   in   1      bus idle (STOP completed)
//  i2c_nack   in   1      one-cycle pulse: slave NACKed the current byte
//  busy       out  1      sequence running
//  done       out  1      table completed (sticky until next start)
//  error      out  1      retries exhausted (sticky until next start)
//  entry_idx  out  IDX_W  entry being processed / failed entry
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-transaction abandons it; no load issued.
//  States: IDLE, FETCH, DELAY, SEND_DEV, SEND_REG, SEND_DATA, WAIT_IDLE, BACKOFF, DONE, ERROR.
//  IDLE/DONE/ERROR + start -> FETCH, entry_idx=0, retry=0, done=error=0, busy=1 next cycle.
//  start while busy: ignored.
//  FETCH: ROM read is combinational on entry_idx. reg==8'hFF -> DELAY, else SEND_DEV.
//  DELAY: wait data*DELAY_TICKS cycles (unit + tick counters, no multiplier); data=0 -> 0 wait;
//   then entry_idx+1 -> FETCH or DONE.
//  SEND_x: when i2c_ready=1 drive i2c_din and pulse i2c_load for 1 cycle; i2c_ready ignored
//   the cycle after a load (engine drops it). Bytes: 8'h70, reg, data; i2c_stop=1 only on data.
//  WAIT_IDLE: after data load wait i2c_idle=1 -> entry_idx+1, retry=0 -> FETCH; after last
//   entry -> DONE (done=1, busy=0).
//  i2c_nack in any SEND_x/WAIT_IDLE: no further loads; retry<MAX_RETRY -> retry+1, wait
//   i2c_idle, BACKOFF RETRY_GAP cycles -> SEND_DEV same entry. retry==MAX_RETRY -> ERROR
//   (error=1, busy=0, entry_idx frozen). NACK coincident with load cycle: NACK wins, load completes.
//  i2c_din holds last value between loads; i2c_stop is 0 except during the data-byte load.
//  entry_idx wraps never: comparison against N_ENTRIES-1 before increment.
// STRUCTURE
//  codec_seq_defs.vh: state encodings, DELAY_REG=8'hFF, entry field slices [15:8]=reg [7:0]=data.
//  Sub-module codec_init_rom: case ROM, in idx[IDX_W-1:0], out entry[15:0]; codec values live
//  there only. Sequencer FSM + delay/backoff/retry counters in codec_init_seq.
// TESTING  (bench: i2c engine model, DELAY_TICKS=10, RETRY_GAP=20, MAX_RETRY=3)
//  ROM {25,AA},{26,55}, start -> loads 70,25,AA(stop) then 70,26,55(stop); done=1, busy=0.
//  Entry {FF,02} between writes -> 20 cycles (+/-1) with no load between STOP and next 70.
//  One NACK on byte 25 -> no AA load; after idle+20 cycles resend 70,25,AA; done=1, error=0.
//  NACK every attempt of entry 1 -> 4 attempts total, error=1, entry_idx=1, done=0.
//  reset_n low during SEND_REG -> all outputs 0 async, no load for 50 cycles after release.
//  start pulsed while busy -> sequence unaffected; start after done -> replays from 70,25.

Source files
------------

// File: rtl/codec_init_seq_pkg.sv
// Shared types and constants for the codec power-up configuration sequencer.
package codec_init_seq_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ENTRY_W = 16;

  // Register address that marks a timed-delay entry instead of an i2c write
  localparam logic [BYTE_W-1:0] DELAY_REG = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DELAY     = 4'd2,
    ST_SEND_DEV  = 4'd3,
    ST_SEND_REG  = 4'd4,
    ST_SEND_DATA = 4'd5,
    ST_WAIT_IDLE = 4'd6,
    ST_BACKOFF   = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERROR     = 4'd9
  } seq_state_e;

  // One table entry: [15:8] register address, [7:0] data (or delay units)
  typedef struct packed {
    logic [BYTE_W-1:0] reg_addr;
    logic [BYTE_W-1:0] data;
  } rom_entry_t;

  // True when the entry is a delay rather than a register write
  function automatic logic is_delay(input rom_entry_t e);
    return e.reg_addr == DELAY_REG;
  endfunction

  // Address byte for a write transaction: 7-bit address followed by R/W=0
  function automatic logic [BYTE_W-1:0] dev_write_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Codec bring-up table: combinational case ROM of {reg, data} entries.
module codec_init_rom
  import codec_init_seq_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [ENTRY_W-1:0] entry
);

  // Table lookup; unused indices read as a zero-length delay
  always_comb begin
    entry = {DELAY_REG, 8'h00};
    case (32'(idx))
      32'd0:  entry = 16'h25AA;
      32'd1:  entry = 16'h2655;
      32'd2:  entry = 16'hFF02;  // settle 2 units after clock setup
      32'd3:  entry = 16'h2733;
      32'd4:  entry = 16'h2800;
      32'd5:  entry = 16'h2901;
      32'd6:  entry = 16'hFF05;  // analog bias ramp
      32'd7:  entry = 16'h2A10;
      32'd8:  entry = 16'h2B10;
      32'd9:  entry = 16'h2C3F;
      32'd10: entry = 16'h2D3F;
      32'd11: entry = 16'h2E01;
      32'd12: entry = 16'hFF01;
      32'd13: entry = 16'h2F80;
      32'd14: entry = 16'h3001;
      32'd15: entry = 16'h3101;
      default: entry = {DELAY_REG, 8'h00};
    endcase
  end

endmodule

// File: rtl/codec_init_seq.sv
// Power-up sequencer: walks the codec table and feeds each write byte-by-byte
// into the i2c byte engine, with timed delays and NACK retry/backoff.
module codec_init_seq
  import codec_init_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h38,
  parameter int unsigned N_ENTRIES   = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned DELAY_TICKS = 25000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [BYTE_W-1:0] i2c_din,
  output logic              i2c_load,
  output logic              i2c_stop,
  input  logic              i2c_ready,
  input  logic              i2c_idle,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  entry_idx
);

  localparam int unsigned TICK_MAX = (DELAY_TICKS > RETRY_GAP) ? DELAY_TICKS : RETRY_GAP;
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);
  localparam int unsigned RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX        = IDX_W'(N_ENTRIES - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST_DELAY = TICK_W'(DELAY_TICKS - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST_GAP   = TICK_W'(RETRY_GAP - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT     = RETRY_W'(MAX_RETRY);
  localparam logic [BYTE_W-1:0]  DEV_BYTE        = dev_write_byte(DEV_ADDR);

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [BYTE_W-1:0]   unit_q, unit_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                abort_q, abort_d;
  logic                load_dly_q;

  logic [BYTE_W-1:0]   din_q, din_d;
  logic                load_q, load_d;
  logic                stop_q, stop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [ENTRY_W-1:0]  rom_word;
  rom_entry_t          entry_c;
  logic                load_block;
  logic                can_load;

  codec_init_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .idx   (idx_q),
    .entry (rom_word)
  );

  assign entry_c = rom_entry_t'(rom_word);

  // Engine drops ready only after it sees a load, so ready is stale for the
  // load cycle and the one after it
  assign load_block = load_q | load_dly_q;
  assign can_load   = i2c_ready & ~load_block & ~i2c_nack;

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      unit_q     <= '0;
      tick_q     <= '0;
      abort_q    <= 1'b0;
      load_dly_q <= 1'b0;
      din_q      <= '0;
      load_q     <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      unit_q     <= unit_d;
      tick_q     <= tick_d;
      abort_q    <= abort_d;
      load_dly_q <= load_q;
      din_q      <= din_d;
      load_q     <= load_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state: table walk, delay/backoff counting and NACK retry decisions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    unit_d  = unit_q;
    tick_d  = tick_q;
    abort_d = abort_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          retry_d = '0;
          abort_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (is_delay(entry_c)) begin
          state_d = ST_DELAY;
          unit_d  = entry_c.data;
          tick_d  = '0;
        end else begin
          state_d = ST_SEND_DEV;
        end
      end

      ST_DELAY: begin
        if (unit_q == '0) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end else if (tick_q == TICK_LAST_DELAY) begin
          tick_d = '0;
          if (unit_q == BYTE_W'(1)) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_FETCH;
            end
          end else begin
            unit_d = unit_q - BYTE_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      ST_SEND_DEV, ST_SEND_REG, ST_SEND_DATA: begin
        if (i2c_nack) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_ERROR;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            abort_d = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else if (can_load) begin
          case (state_q)
            ST_SEND_DEV: state_d = ST_SEND_REG;
            ST_SEND_REG: state_d = ST_SEND_DATA;
            default: begin
              state_d = ST_WAIT_IDLE;
              abort_d = 1'b0;
            end
          endcase
        end
      end

      ST_WAIT_IDLE: begin
        if (!abort_q && i2c_nack) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_ERROR;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            abort_d = 1'b1;
          end
        end else if (i2c_idle && !load_block) begin
          if (abort_q) begin
            abort_d = 1'b0;
            tick_d  = '0;
            state_d = ST_BACKOFF;
          end else begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
      end

      ST_BACKOFF: begin
        if (tick_q == TICK_LAST_GAP) begin
          tick_d  = '0;
          state_d = ST_SEND_DEV;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: byte/load/stop for the engine and status flags, registered
  always_comb begin
    din_d  = din_q;
    load_d = 1'b0;
    stop_d = 1'b0;

    if (can_load) begin
      case (state_q)
        ST_SEND_DEV: begin
          din_d  = DEV_BYTE;
          load_d = 1'b1;
        end
        ST_SEND_REG: begin
          din_d  = entry_c.reg_addr;
          load_d = 1'b1;
        end
        ST_SEND_DATA: begin
          din_d  = entry_c.data;
          load_d = 1'b1;
          stop_d = 1'b1;
        end
        default: ;
      endcase
    end

    busy_d  = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  assign i2c_din   = din_q;
  assign i2c_load  = load_q;
  assign i2c_stop  = stop_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign entry_idx = idx_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq with a simple i2c byte-engine model.
module tb_codec_init_seq;

  localparam int unsigned IDX_W = 4;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             start     = 1'b0;
  logic [7:0]       i2c_din;
  logic             i2c_load;
  logic             i2c_stop;
  logic             i2c_ready = 1'b1;
  logic             i2c_idle  = 1'b1;
  logic             i2c_nack  = 1'b0;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] entry_idx;

  codec_init_seq #(
    .DEV_ADDR    (7'h38),
    .N_ENTRIES   (4),
    .IDX_W       (IDX_W),
    .DELAY_TICKS (10),
    .MAX_RETRY   (3),
    .RETRY_GAP   (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .i2c_din   (i2c_din),
    .i2c_load  (i2c_load),
    .i2c_stop  (i2c_stop),
    .i2c_ready (i2c_ready),
    .i2c_idle  (i2c_idle),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .entry_idx (entry_idx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Engine model state and transaction log ({stop, byte} per load)
  logic [8:0] log_q[$];
  int         load_cyc[$];
  logic [8:0] exp_q[$];
  int         cyc           = 0;
  int         proto_err     = 0;
  int         nack_given    = 0;
  int         nack_limit    = 0;
  logic [7:0] nack_byte     = 8'h00;
  int         last_nack_cyc = 0;
  logic       clr           = 1'b0;
  int         cnt           = 0;
  int         cnt2          = 0;
  logic       stop_pend     = 1'b0;
  logic       nack_pend     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // i2c byte engine: accept a byte, busy a few cycles, then ready/NACK/STOP
  always @(posedge clk) begin
    i2c_nack <= 1'b0;
    if (!reset_n) begin
      i2c_ready <= 1'b1;
      i2c_idle  <= 1'b1;
      cnt       <= 0;
      cnt2      <= 0;
      stop_pend <= 1'b0;
      nack_pend <= 1'b0;
    end else begin
      if (clr) begin
        log_q.delete();
        load_cyc.delete();
        nack_given <= 0;
      end
      proto_err <= proto_err + (((i2c_load && !i2c_ready) || (!i2c_load && i2c_stop)) ? 1 : 0);
      if (i2c_load) begin
        log_q.push_back({i2c_stop, i2c_din});
        load_cyc.push_back(cyc);
        i2c_ready <= 1'b0;
        i2c_idle  <= 1'b0;
        cnt       <= 4;
        stop_pend <= i2c_stop;
        if (nack_given < nack_limit && i2c_din == nack_byte) begin
          nack_pend  <= 1'b1;
          nack_given <= nack_given + 1;
        end else begin
          nack_pend <= 1'b0;
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          if (nack_pend) begin
            i2c_nack      <= 1'b1;
            last_nack_cyc <= cyc;
            nack_pend     <= 1'b0;
            cnt2          <= 3;
          end else if (stop_pend) begin
            cnt2 <= 3;
          end else begin
            i2c_ready <= 1'b1;
          end
        end
      end else if (cnt2 != 0) begin
        cnt2 <= cnt2 - 1;
        if (cnt2 == 1) begin
          i2c_idle  <= 1'b1;
          i2c_ready <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_log(input string tag);
    check($sformatf("%s_nloads", tag), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size())
        check($sformatf("%s_load%0d", tag, i), log_q[i], exp_q[i]);
    end
  endtask

  task automatic clear_log();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic e,
                              input logic [IDX_W-1:0] idx);
    check({tag, "_busy"}, busy, b);
    check({tag, "_done"}, done, d);
    check({tag, "_error"}, error, e);
    check({tag, "_idx"}, entry_idx, idx);
  endtask

  initial begin
    bit ok;
    int gap0;
    int gap1;
    int diff;
    int wait_gap;

    // Reset values
    repeat (3) @(negedge clk);
    check_status("rst", 1'b0, 1'b0, 1'b0, 4'd0);
    check("rst_load", i2c_load, 0);
    check("rst_stop", i2c_stop, 0);
    check("rst_din", i2c_din, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain run: two writes, a 2-unit delay, one more write
    clear_log();
    pulse_start();
    check_status("a_start", 1'b1, 1'b0, 1'b0, 4'd0);
    wait_end(ok);
    check("a_finished", ok, 1);
    exp_q = '{9'h070, 9'h025, 9'h1AA, 9'h070, 9'h026, 9'h155, 9'h070, 9'h027, 9'h133};
    compare_log("a");
    check_status("a_end", 1'b0, 1'b1, 1'b0, 4'd3);
    gap0 = (load_cyc.size() >= 7) ? load_cyc[3] - load_cyc[2] : 0;
    gap1 = (load_cyc.size() >= 7) ? load_cyc[6] - load_cyc[5] : 0;
    diff = gap1 - gap0;
    check("a_delay_gap_in_range", (diff >= 19 && diff <= 21), 1);

    // Single NACK on the register byte of entry 0, then retry
    nack_byte  = 8'h25;
    nack_limit = 1;
    clear_log();
    pulse_start();
    check_status("b_start", 1'b1, 1'b0, 1'b0, 4'd0);
    wait_end(ok);
    check("b_finished", ok, 1);
    exp_q = '{9'h070, 9'h025, 9'h070, 9'h025, 9'h1AA, 9'h070, 9'h026, 9'h155,
              9'h070, 9'h027, 9'h133};
    compare_log("b");
    check_status("b_end", 1'b0, 1'b1, 1'b0, 4'd3);
    wait_gap = (load_cyc.size() >= 3) ? load_cyc[2] - last_nack_cyc : 0;
    check("b_backoff_in_range", (wait_gap >= 21 && wait_gap <= 30), 1);

    // Every attempt of entry 1 NACKed: 4 attempts then error
    nack_byte  = 8'h26;
    nack_limit = 100;
    clear_log();
    pulse_start();
    wait_end(ok);
    check("c_finished", ok, 1);
    repeat (20) @(negedge clk);
    nack_limit = 0;
    exp_q = '{9'h070, 9'h025, 9'h1AA, 9'h070, 9'h026, 9'h070, 9'h026,
              9'h070, 9'h026, 9'h070, 9'h026};
    compare_log("c");
    check_status("c_end", 1'b0, 1'b0, 1'b1, 4'd1);

    // Reset asserted while the register byte is pending
    clear_log();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (log_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("d_first_load_seen", ok, 1);
    reset_n = 1'b0;
    #1;
    check_status("d_async", 1'b0, 1'b0, 1'b0, 4'd0);
    check("d_async_load", i2c_load, 0);
    check("d_async_stop", i2c_stop, 0);
    check("d_async_din", i2c_din, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    exp_q = '{9'h070};
    compare_log("d");
    check_status("d_after", 1'b0, 1'b0, 1'b0, 4'd0);

    // Start pulsed mid-sequence is ignored; start after done replays
    clear_log();
    pulse_start();
    repeat (15) @(negedge clk);
    check("e_busy_before_restart", busy, 1);
    pulse_start();
    wait_end(ok);
    check("e_finished", ok, 1);
    exp_q = '{9'h070, 9'h025, 9'h1AA, 9'h070, 9'h026, 9'h155, 9'h070, 9'h027, 9'h133};
    compare_log("e");
    check_status("e_end", 1'b0, 1'b1, 1'b0, 4'd3);
    clear_log();
    pulse_start();
    check("e2_done_cleared", done, 0);
    wait_end(ok);
    check("e2_finished", ok, 1);
    compare_log("e2");
    check_status("e2_end", 1'b0, 1'b1, 1'b0, 4'd3);

    check("protocol_errors", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
